lsu_mem_responder: RTL and testbench
====================================

LSU_MEM_RESPONDER -- requirements
Module: lsu_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the data store (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning wait states between request acceptance and response (0..7).
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req_valid  input  1  initiator presents a request.
REQ-006 o_req_ready  output  1  responder can accept a request.
REQ-007 i_req_we  input  1  1 = store, 0 = load.
REQ-008 i_req_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 i_req_wdata  input  32  lane-aligned store data.
REQ-010 i_req_strb  input  4  byte-lane write enables; bit n enables wdata[8n+7:8n].
REQ-011 o_rsp_valid  output  1  response available.
REQ-012 i_rsp_ready  input  1  initiator accepts the response.
REQ-013 o_rsp_rdata  output  32  full aligned word read; lane extraction and sign extension are done by the initiator.
REQ-014 o_rsp_err  output  1  address outside the data store.

Function
REQ-015 SHALL implement a state machine with states IDLE, WAIT and RESP.
REQ-016 o_req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with i_req_valid & o_req_ready.
REQ-017 On acceptance, SHALL latch we, word index addr[31:2], wdata and strb. Go to WAIT if WAIT_CYCLES > 0, else RESP.
REQ-018 WAIT SHALL count exactly WAIT_CYCLES cycles, then enter RESP.
REQ-019 Total latency from the acceptance edge to o_rsp_valid high SHALL be WAIT_CYCLES+1 cycles.
REQ-020 The memory access SHALL occur exactly once, on the edge entering RESP.
  - Store: write only the lanes enabled by strb; strb = 0 writes nothing.
  - Load: capture the full word into the response register.
REQ-021 o_rsp_valid SHALL be 1 throughout RESP. o_rsp_rdata and o_rsp_err SHALL be stable while o_rsp_valid & !i_rsp_ready.
REQ-022 RESP SHALL return to IDLE on i_rsp_ready. A new request SHALL not be accepted in the same cycle, so there is one outstanding request at most.
REQ-023 If the word index is >= DEPTH_WORDS, the responder SHALL NOT modify the store, SHALL set o_rsp_err=1 and SHALL set o_rsp_rdata=0.
REQ-024 Store responses SHALL return o_rsp_rdata=0 and o_rsp_err per REQ-023.
REQ-025 Request inputs SHALL be ignored outside the acceptance cycle.

Reset
REQ-026 Reset SHALL force state=IDLE, wait counter=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
  - Consequence: o_req_ready=1 during and after reset.
REQ-027 Reset mid-operation (WAIT or RESP) SHALL abandon the request. A store still in WAIT SHALL not be written.
REQ-028 Data store contents SHALL NOT be reset and are undefined until written.

Structure
REQ-029 The state enum lsu_rsp_state_e and the width constants for the address, data and strobe SHALL live in singlecycle_pkg.
REQ-030 Storage SHALL be a sub-module dmem_array with a synchronous byte-enable write port and a synchronous read port; control and FSM stay in lsu_mem_responder.

Verification
REQ-031 Store then load, WAIT_CYCLES=1:
  - Store addr 0x10, wdata 0xDEADBEEF, strb 1111.
  - Then load addr 0x10.
  - Required: rdata 0xDEADBEEF, err 0, o_rsp_valid on the 2nd edge after acceptance.
REQ-032 Partial strobe:
  - Store 0x11223344 to 0x20 with strb 1111.
  - Then store 0x0000AA00 with strb 0010.
  - Required: load of 0x20 returns 0x1122AA44.
REQ-033 Backpressure:
  - Hold i_rsp_ready=0 for 5 cycles in RESP.
  - Required: o_rsp_valid and rdata stay stable, o_req_ready=0, a concurrent i_req_valid is not accepted.
REQ-034 Out of range, DEPTH_WORDS=1024:
  - Store 0xFFFFFFFF to addr 0x1000.
  - Required: err 1, rdata 0, and a load of 0x0 returns its previously written value unchanged.
REQ-035 Reset during WAIT (WAIT_CYCLES=3):
  - Assert i_rst one cycle after accepting a store of 0x55 to 0x40, where 0x40 previously held 0x12345678.
  - Required: o_rsp_valid 0, state IDLE, and a later load of 0x40 returns 0x12345678.
REQ-036 WAIT_CYCLES=0:
  - Issue back-to-back requests with i_rsp_ready tied 1.
  - Required: one response per 2 cycles, each on the edge after acceptance.

Source files
------------

// File: rtl/singlecycle_pkg.sv
// Shared widths and the responder state encoding for the LSU data-memory path.
package singlecycle_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = DATA_W / 8;
    localparam int unsigned WORD_IDX_W = ADDR_W - 2;
    localparam int unsigned WCNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_rsp_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data store: synchronous byte-enable write, synchronous registered read.
// Contents are never reset.
module dmem_array
    import singlecycle_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_we,
    input  logic [STRB_W-1:0]              i_be,
    input  logic                           i_re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [DATA_W-1:0]              i_wdata,
    output logic [DATA_W-1:0]              o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (i_be[b]) begin
                    mem_q[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            rdata_q <= mem_q[i_idx];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/lsu_mem_responder.sv
// Single-outstanding LSU memory responder: accepts one request, waits WAIT_CYCLES,
// performs the access on the edge entering RESP and holds the response until taken.
module lsu_mem_responder
    import singlecycle_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [STRB_W-1:0] i_req_strb,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WCNT_W'(WAIT_CYCLES - 1);

    lsu_rsp_state_e state_q, state_d;
    logic [WCNT_W-1:0]     cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [WORD_IDX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic                  rsp_load_q, rsp_load_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  enter_resp;
    logic                  acc_we;
    logic [WORD_IDX_W-1:0] acc_idx;
    logic [DATA_W-1:0]     acc_wdata;
    logic [STRB_W-1:0]     acc_strb;
    logic                  in_range;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_W-1:0]     mem_rdata;

    // With zero wait states the access happens on the acceptance edge itself,
    // so it must see the live request rather than the not-yet-latched copy.
    assign acc_we    = (state_q == ST_IDLE) ? i_req_we               : we_q;
    assign acc_idx   = (state_q == ST_IDLE) ? i_req_addr[ADDR_W-1:2] : idx_q;
    assign acc_wdata = (state_q == ST_IDLE) ? i_req_wdata            : wdata_q;
    assign acc_strb  = (state_q == ST_IDLE) ? i_req_strb             : strb_q;

    assign in_range = ({2'b00, acc_idx} < 32'(DEPTH_WORDS));
    assign mem_we   = enter_resp & acc_we & in_range;
    assign mem_re   = enter_resp & ~acc_we & in_range;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        rsp_load_d  = rsp_load_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;
        o_req_ready = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    idx_d   = i_req_addr[ADDR_W-1:2];
                    wdata_d = i_req_wdata;
                    strb_d  = i_req_strb;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d    = ST_IDLE;
                    rsp_load_d = 1'b0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_resp) begin
            rsp_load_d = ~acc_we & in_range;
            rsp_err_d  = ~in_range;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rsp_load_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            rsp_load_q <= rsp_load_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_dmem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_be    (acc_strb),
        .i_re    (mem_re),
        .i_idx   (acc_idx[IDX_W-1:0]),
        .i_wdata (acc_wdata),
        .o_rdata (mem_rdata)
    );

    // Stores and out-of-range accesses return zero; the read register is only valid for loads.
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_rdata = rsp_load_q ? mem_rdata : '0;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench: three responders (WAIT_CYCLES 1, 3, 0) driven by directed requests;
// a negedge monitor checks latency, backpressure stability and response data.
module tb_lsu_mem_responder;

    localparam int N = 3;
    localparam int WC [N] = '{1, 3, 0};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst;
    logic [N-1:0] req_valid, req_ready, req_we;
    logic [N-1:0] rsp_valid, rsp_ready, rsp_err;
    logic [31:0]  req_addr  [N];
    logic [31:0]  req_wdata [N];
    logic [3:0]   req_strb  [N];
    logic [31:0]  rsp_rdata [N];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            lsu_mem_responder #(
                .DEPTH_WORDS(1024),
                .WAIT_CYCLES(WC[g])
            ) u_dut (
                .i_clk       (clk),
                .i_rst       (rst[g]),
                .i_req_valid (req_valid[g]),
                .o_req_ready (req_ready[g]),
                .i_req_we    (req_we[g]),
                .i_req_addr  (req_addr[g]),
                .i_req_wdata (req_wdata[g]),
                .i_req_strb  (req_strb[g]),
                .o_rsp_valid (rsp_valid[g]),
                .i_rsp_ready (rsp_ready[g]),
                .o_rsp_rdata (rsp_rdata[g]),
                .o_rsp_err   (rsp_err[g])
            );
        end
    endgenerate

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q [N][$];

    int          acc_cyc    [N];
    logic [N-1:0] prev_valid, prev_ready, prev_err;
    logic [31:0] prev_rdata [N];
    bit          burst_chk  = 1'b0;
    int          last_acc2  = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst[k]) begin
                prev_valid[k] = 1'b0;
            end else begin
                if (req_valid[k] && req_ready[k]) begin
                    if (k == 2 && burst_chk && last_acc2 >= 0)
                        chk("b2b_spacing", 32'(cyc - last_acc2), 32'd2);
                    if (k == 2) last_acc2 = cyc;
                    acc_cyc[k] = cyc;
                end
                if (rsp_valid[k]) begin
                    chk($sformatf("req_ready_in_resp[%0d]", k), 32'(req_ready[k]), 32'd0);
                    if (!prev_valid[k])
                        chk($sformatf("latency[%0d]", k), 32'(cyc - acc_cyc[k]), 32'(WC[k] + 1));
                    else if (!prev_ready[k]) begin
                        chk($sformatf("hold_rdata[%0d]", k), rsp_rdata[k], prev_rdata[k]);
                        chk($sformatf("hold_err[%0d]", k), 32'(rsp_err[k]), 32'(prev_err[k]));
                    end
                    if (rsp_ready[k]) begin
                        if (exp_q[k].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_rsp[%0d] actual=%h required=none", k, rsp_rdata[k]);
                        end else begin
                            exp_t e;
                            e = exp_q[k].pop_front();
                            chk({e.name, "_rdata"}, rsp_rdata[k], e.rdata);
                            chk({e.name, "_err"}, 32'(rsp_err[k]), 32'(e.err));
                        end
                    end
                end
                prev_valid[k] = rsp_valid[k];
            end
            prev_ready[k] = rsp_ready[k];
            prev_rdata[k] = rsp_rdata[k];
            prev_err[k]   = rsp_err[k];
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic issue(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input bit push, input string name);
        bit ok;
        exp_t e;
        ok = 1'b0;
        if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.name  = name;
            exp_q[k].push_back(e);
        end
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_strb[k]  = strb;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_we[k]    = 1'b1;
        req_addr[k]  = 32'h0000_0010;
        req_wdata[k] = 32'h0BAD_0BAD;
        req_strb[k]  = 4'hF;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout_%s actual=not_accepted required=accepted", name);
        end
    endtask

    task automatic wait_drain(input int k);
        for (int i = 0; i < 100; i++) begin
            if (exp_q[k].size() == 0) break;
            @(negedge clk);
        end
        if (exp_q[k].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout[%0d] actual=%0d_pending required=0", k, exp_q[k].size());
            exp_q[k].delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst       = '1;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = '1;
        for (int k = 0; k < N; k++) begin
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_strb[k]  = '0;
            acc_cyc[k]   = 0;
        end
        #2;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_req_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("rst_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("rst_rdata[%0d]", k), rsp_rdata[k], 32'd0);
            chk($sformatf("rst_err[%0d]", k), 32'(rsp_err[k]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = '0;

        // WAIT_CYCLES=1 instance
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1, "st_10");
        issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, "ld_10");
        wait_drain(0);
        issue(0, 0, 32'h13, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, "ld_13_lowbits");
        issue(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 1, "st_20");
        issue(0, 1, 32'h20, 32'h0000AA00, 4'b0010, 32'h0, 0, 1, "st_20_lane1");
        issue(0, 0, 32'h20, 32'h0, 4'h0, 32'h1122AA44, 0, 1, "ld_20_partial");
        issue(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 1, "st_20_strb0");
        issue(0, 0, 32'h20, 32'h0, 4'h0, 32'h1122AA44, 0, 1, "ld_20_after_strb0");
        issue(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 0, 1, "st_0");
        issue(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 1, "st_oor");
        issue(0, 0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1, "ld_0_after_oor");
        issue(0, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 1, 1, "ld_oor");
        issue(0, 1, 32'hFFC, 32'hA5A5_5A5A, 4'hF, 32'h0, 0, 1, "st_last");
        issue(0, 0, 32'hFFC, 32'h0, 4'h0, 32'hA5A5_5A5A, 0, 1, "ld_last");
        wait_drain(0);

        // Backpressure with a competing request that must not be accepted
        rsp_ready[0] = 1'b0;
        issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, "bp_ld_10");
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h10;
        req_wdata[0] = 32'h0;
        req_strb[0]  = 4'hF;
        repeat (7) @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        wait_drain(0);
        issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, "ld_10_after_bp");
        wait_drain(0);

        // WAIT_CYCLES=3 instance: reset abandons a store still waiting
        issue(1, 1, 32'h40, 32'h12345678, 4'hF, 32'h0, 0, 1, "w3_st_40");
        issue(1, 0, 32'h40, 32'h0, 4'h0, 32'h12345678, 0, 1, "w3_ld_40");
        wait_drain(1);
        issue(1, 1, 32'h40, 32'h00000055, 4'hF, 32'h0, 0, 0, "w3_st_40_abandon");
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("midrst_req_ready", 32'(req_ready[1]), 32'd1);
        chk("midrst_rdata", rsp_rdata[1], 32'd0);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        #1;
        chk("postrst_idle_ready", 32'(req_ready[1]), 32'd1);
        chk("postrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk);
        #1;
        issue(1, 0, 32'h40, 32'h0, 4'h0, 32'h12345678, 0, 1, "w3_ld_40_after_rst");
        wait_drain(1);

        // WAIT_CYCLES=0 instance: back-to-back requests, ready tied high
        burst_chk = 1'b1;
        last_acc2 = -1;
        issue(2, 1, 32'h0, 32'h01010101, 4'hF, 32'h0, 0, 1, "w0_st_0");
        issue(2, 1, 32'h4, 32'h02020202, 4'hF, 32'h0, 0, 1, "w0_st_4");
        issue(2, 1, 32'h8, 32'h0304_0506, 4'b1001, 32'h0, 0, 1, "w0_st_8");
        issue(2, 0, 32'h0, 32'h0, 4'h0, 32'h01010101, 0, 1, "w0_ld_0");
        issue(2, 0, 32'h4, 32'h0, 4'h0, 32'h02020202, 0, 1, "w0_ld_4");
        issue(2, 1, 32'h2000, 32'h0, 4'hF, 32'h0, 1, 1, "w0_st_oor");
        issue(2, 1, 32'h4, 32'hFF00FF00, 4'b0100, 32'h0, 0, 1, "w0_st_4_lane2");
        issue(2, 0, 32'h4, 32'h0, 4'h0, 32'h0200_0202, 0, 1, "w0_ld_4_lane2");
        wait_drain(2);
        burst_chk = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
